phasecalc_sched: RTL and testbench

- Round-robin scheduler that shares one phasecalc unit (start/busy handshake, 13-bit signed X/Y in, 19-bit signed Q8.10 angle out) between NREQ requesters, e.g. the per-channel Hilbert filter I/Q outputs.
- Accepts one X/Y pair at a time and sequences the shared unit through start, busy-rise and busy-fall.
- Returns the angle tagged with the requester index.
- Sits between the Hilbert filter channel outputs and the single phasecalc instance.

---
 rtl/phasecalc_pkg.sv | 19 +
 rtl/phasecalc_sched_rr_arbiter.sv | 33 +++
 rtl/phasecalc_sched.sv | 139 +++++++++++++
 tb/tb_phasecalc_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phasecalc_pkg.sv
// phasecalc_pkg: shared constants and state encoding for the phasecalc scheduler.
package phasecalc_pkg;

    // Operand and result widths of the shared phasecalc unit.
    localparam int INW        = 13;
    localparam int OUTW       = 19;

    // The angle result is signed Q8.10: ten fraction bits, one unit = 1/1024 rad.
    localparam int ANGLE_FRAC = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/phasecalc_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first active request at or above ptr.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    // Scan NREQ positions starting at ptr with wrap-around; the first hit wins.
    always_comb begin
        int  k;
        logic found;
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                idx      = IDW'(k);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phasecalc_sched.sv
// phasecalc_sched: shares one phasecalc unit between NREQ requesters, one X/Y pair at a time,
// and returns the angle tagged with the requester index.
// Optional watchdog on the busy handshake: define PHASECALC_SCHED_TIMEOUT_EN.
module phasecalc_sched #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int INW         = phasecalc_pkg::INW,
    parameter int OUTW        = phasecalc_pkg::OUTW,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*INW-1:0] req_x,
    input  logic [NREQ*INW-1:0] req_y,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [OUTW-1:0]     rsp_angle,
    output logic                rsp_err,
    output logic                pc_start,
    output logic [INW-1:0]      pc_x,
    output logic [INW-1:0]      pc_y,
    input  logic                pc_busy,
    input  logic [OUTW-1:0]     pc_angle
);

    import phasecalc_pkg::*;

    if (IDW != $clog2(NREQ) || NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("phasecalc_sched: inconsistent parameters");
    end

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cur_id;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            accept;
    logic            done_ok;
    logic            timed_out;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Grants are only offered while idle and out of reset, so no requester sees a false accept.
    assign req_ready = (state == ST_IDLE && reset) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign done_ok   = (state == ST_WAIT_LO) && !pc_busy;

`ifdef PHASECALC_SCHED_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC);
    logic [CNTW-1:0] wd_cnt;
    logic            in_wait;

    assign in_wait   = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);
    assign timed_out = in_wait && (wd_cnt == CNTW'(TIMEOUT_CYC - 1));

    // Watchdog: cleared on the way into START, counts every waiting cycle; latches the error flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wd_cnt  <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (accept)       wd_cnt <= '0;
            else if (in_wait) wd_cnt <= wd_cnt + 1'b1;
            if (done_ok)        rsp_err <= 1'b0;
            else if (timed_out) rsp_err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and the decoded one-cycle strobes.
    always_comb begin
        state_next = state;
        pc_start   = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            ST_IDLE:    if (accept) state_next = ST_START;
            ST_START: begin
                pc_start   = 1'b1;
                state_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: if (pc_busy) state_next = ST_WAIT_LO;
            ST_WAIT_LO: if (!pc_busy) state_next = ST_RESP;
            ST_RESP: begin
                rsp_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default:    state_next = ST_IDLE;
        endcase
        if (timed_out) state_next = ST_RESP;
    end

    // Operand capture and pointer advance on accept; result registration on completion or timeout.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr       <= '0;
            cur_id    <= '0;
            pc_x      <= '0;
            pc_y      <= '0;
            rsp_id    <= '0;
            rsp_angle <= '0;
        end else begin
            if (accept) begin
                pc_x   <= req_x[int'(grant_idx) * INW +: INW];
                pc_y   <= req_y[int'(grant_idx) * INW +: INW];
                cur_id <= grant_idx;
                ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (done_ok) begin
                rsp_id    <= cur_id;
                rsp_angle <= pc_angle;
            end else if (timed_out) begin
                rsp_id    <= cur_id;
                rsp_angle <= '0;
            end
        end
    end

endmodule

// File: tb/tb_phasecalc_sched.sv
// tb_phasecalc_sched: directed bench for phasecalc_sched with a behavioural phasecalc unit
// (busy high for 16 cycles, rising one idle cycle after the start pulse) and a spec-level model.
`timescale 1ns/1ps
module tb_phasecalc_sched;
    import phasecalc_pkg::*;

    localparam int NREQ        = 4;
    localparam int IDW         = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int BUSY_LEN    = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*INW-1:0] req_x = '0;
    logic [NREQ*INW-1:0] req_y = '0;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [OUTW-1:0]     rsp_angle;
    logic                rsp_err;
    logic                pc_start;
    logic [INW-1:0]      pc_x;
    logic [INW-1:0]      pc_y;
    logic                pc_busy;
    logic [OUTW-1:0]     pc_angle;

    int n_tests = 0;
    int n_fail  = 0;

    phasecalc_sched #(
        .NREQ        (NREQ),
        .IDW         (IDW),
        .INW         (INW),
        .OUTW        (OUTW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_angle (rsp_angle),
        .rsp_err   (rsp_err),
        .pc_start  (pc_start),
        .pc_x      (pc_x),
        .pc_y      (pc_y),
        .pc_busy   (pc_busy),
        .pc_angle  (pc_angle)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal atan2 in Q8.10, rounded to nearest.
    function automatic int ideal_angle(input int x, input int y);
        real a;
        a = $atan2(real'(y), real'(x)) * real'(1 << ANGLE_FRAC);
        return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- behavioural phasecalc unit ----------------
    logic            pend    = 1'b0;
    logic            busy_r  = 1'b0;
    int              busy_cnt = 0;
    logic [OUTW-1:0] ang_r   = '0;
    bit              stuck   = 1'b0;

    always @(posedge clock) begin
        if (!reset) begin
            pend   <= 1'b0;
            busy_r <= 1'b0;
            busy_cnt <= 0;
        end else begin
            pend <= pc_start;
            if (pend) begin
                busy_r   <= 1'b1;
                busy_cnt <= BUSY_LEN - 1;
            end else if (busy_r) begin
                if (busy_cnt == 0) busy_r <= 1'b0;
                else               busy_cnt <= busy_cnt - 1;
            end
        end
        if (pc_start) ang_r <= OUTW'(ideal_angle(int'($signed(pc_x)), int'($signed(pc_y))));
    end

    assign pc_busy  = busy_r | stuck;
    // Garbage while busy so a result captured at the wrong moment is visible.
    assign pc_angle = pc_busy ? OUTW'(32'h2AAAA) : ang_r;

    // ---------------- cycle bookkeeping ----------------
    int cyc      = 0;
    bit rst_edge = 1'b0;
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_edge <= !reset;
    end

    // ---------------- spec-level model and compare ----------------
    int  ptr_m = 0;
    bit  outstanding = 1'b0;
    int  cur_id = 0, cur_x = 0, cur_y = 0;
    int  exp_px = 0, exp_py = 0;
    int  acc_cyc = -100, due_cyc = -100;
    bit  prev_busy = 1'b0;
    int  last_id = 0, last_ang = 0, last_err = 0;
    bit  tmo_mode = 1'b0;
    bit  cur_tmo = 1'b0;
    int  rsp_count = 0;
    int  acc_seen = 0, start_seen = 0, rsp_seen = 0;
    int  dut_grants[$];
    int  rsp_ids[$];

    always @(negedge clock) begin
        logic [NREQ-1:0] exp_ready;
        bit found;
        int k;
        if (cyc > 0) begin
            if (rst_edge) begin
                check("rst_rsp_valid", rsp_valid, 0);
                check("rst_rsp_id", rsp_id, 0);
                check("rst_rsp_angle", $signed(rsp_angle), 0);
                check("rst_rsp_err", rsp_err, 0);
                check("rst_pc_start", pc_start, 0);
                check("rst_pc_x", $signed(pc_x), 0);
                check("rst_pc_y", $signed(pc_y), 0);
                ptr_m = 0; outstanding = 0; exp_px = 0; exp_py = 0;
                acc_cyc = -100; due_cyc = -100;
                last_id = 0; last_ang = 0; last_err = 0;
            end
            exp_ready = '0;
            found = 0;
            if (!outstanding && reset) begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (ptr_m + i) % NREQ;
                    if (!found && req_valid[k]) begin
                        exp_ready[k] = 1'b1;
                        found = 1;
                    end
                end
            end
            check("req_ready", req_ready, exp_ready);
            check("ready_onehot", $countones(req_ready) <= 1, 1);
            check("pc_x", $signed(pc_x), exp_px);
            check("pc_y", $signed(pc_y), exp_py);
            check("pc_start", pc_start, cyc == acc_cyc + 1);
            if (pc_start) start_seen = cyc;
            if (|(req_valid & req_ready)) begin
                dut_grants.push_back(onehot_idx(req_valid & req_ready));
                acc_seen = cyc;
            end
            if (found) begin
                k = onehot_idx(exp_ready);
                outstanding = 1;
                cur_id  = k;
                cur_x   = int'($signed(req_x[k*INW +: INW]));
                cur_y   = int'($signed(req_y[k*INW +: INW]));
                exp_px  = cur_x;
                exp_py  = cur_y;
                ptr_m   = (k + 1) % NREQ;
                acc_cyc = cyc;
                cur_tmo = tmo_mode;
                due_cyc = tmo_mode ? cyc + TIMEOUT_CYC + 2 : -100;
            end
            // The result is registered in the cycle busy is first seen low again; it shows a cycle later.
            if (outstanding && !cur_tmo && cyc > acc_cyc + 1 && prev_busy && !pc_busy)
                due_cyc = cyc + 1;
            check("rsp_valid", rsp_valid, cyc == due_cyc);
            if (cyc == due_cyc) begin
                outstanding = 0;
                last_id  = cur_id;
                last_ang = cur_tmo ? 0 : ideal_angle(cur_x, cur_y);
                last_err = cur_tmo ? 1 : 0;
            end
            check("rsp_id", rsp_id, last_id);
            check("rsp_angle", $signed(rsp_angle), last_ang);
            check("rsp_err", rsp_err, last_err);
            if (rsp_valid) begin
                rsp_count++;
                rsp_ids.push_back(int'(rsp_id));
                rsp_seen = cyc;
            end
        end
        prev_busy = pc_busy;
    end

    // ---------------- stimulus helpers ----------------
    bit keep_valid = 1'b0;

    // One clock: accepted requests drop valid unless they are being held for the fairness run.
    task automatic step();
        logic [NREQ-1:0] drop;
        @(negedge clock);
        drop = keep_valid ? '0 : (req_valid & req_ready);
        @(posedge clock);
        #1;
        req_valid = req_valid & ~drop;
    endtask

    task automatic set_req(input int k, input int x, input int y);
        req_x[k*INW +: INW] = INW'(x);
        req_y[k*INW +: INW] = INW'(y);
        req_valid[k] = 1'b1;
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int start = rsp_count;
        for (int i = 0; i < budget && (rsp_count - start) < n; i++) step();
        check("rsp_arrived", rsp_count - start, n);
    endtask

    task automatic abs_close(input string name, input int act, input int exp);
        int d = act - exp;
        if (d < 0) d = -d;
        check(name, d <= 2, 1);
        if (d > 2) $display("  %s angle was %0d, wanted %0d", name, act, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: run still active at %0t, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int n0;
        int cnt[NREQ];
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Single request: start one cycle after accept, result after 4 + 16 cycles.
        set_req(0, 1000, 0);
        wait_rsps(1, 100);
        check("single_start_lat", start_seen - acc_seen, 1);
        check("single_rsp_lat", rsp_seen - acc_seen, 4 + BUSY_LEN);
        check("single_id", rsp_id, 0);
        check("single_angle", $signed(rsp_angle), 0);
        step();

        // Quadrants: +pi/2 and pi.
        set_req(2, 0, 1000);
        wait_rsps(1, 100);
        check("quad_pi2_id", rsp_id, 2);
        abs_close("quad_pi2_angle", int'($signed(rsp_angle)), 1608);
        set_req(2, -1000, 0);
        wait_rsps(1, 100);
        abs_close("quad_pi_angle", int'($signed(rsp_angle)), 3217);

        // Extreme operands, sign preserved through the pass-through.
        set_req(1, -4096, -1);
        wait_rsps(1, 100);
        set_req(3, 4095, -4096);
        wait_rsps(1, 100);

        // Reset while waiting for busy to fall: no result, everything zero, then req0 wins over req3.
        set_req(1, 500, -700);
        for (int i = 0; i < 50 && !pc_busy; i++) step();
        check("mid_busy_seen", pc_busy, 1);
        repeat (3) step();
        reset = 1'b0;
        n0 = rsp_count;
        set_req(0, 1000, 1000);
        set_req(3, -300, 200);
        repeat (3) step();
        check("mid_no_rsp", rsp_count - n0, 0);
        reset = 1'b1;
        n0 = dut_grants.size();
        for (int i = 0; i < 50 && dut_grants.size() == n0; i++) step();
        check("rst_first_grant", (dut_grants.size() > n0) ? dut_grants[n0] : -1, 0);
        wait_rsps(2, 200);
        check("rst_second_id", rsp_id, 3);

        // Fairness: all four held valid for eight operations.
        step();
        dut_grants.delete();
        rsp_ids.delete();
        keep_valid = 1'b1;
        for (int k = 0; k < NREQ; k++) set_req(k, (k + 1) * 250 - 600, 700 - k * 400);
        wait_rsps(8, 400);
        req_valid = '0;
        keep_valid = 1'b0;
        for (int i = 0; i < 8; i++)
            check("fair_grant_order", (dut_grants.size() > i) ? dut_grants[i] : -1, i % NREQ);
        for (int k = 0; k < NREQ; k++) cnt[k] = 0;
        foreach (rsp_ids[i]) if (rsp_ids[i] >= 0 && rsp_ids[i] < NREQ) cnt[rsp_ids[i]]++;
        for (int k = 0; k < NREQ; k++) check("fair_count", cnt[k], 2);
        repeat (3) step();

`ifdef PHASECALC_SCHED_TIMEOUT_EN
        // Watchdog: busy stuck high, error result after the timeout, then a normal operation.
        stuck = 1'b1;
        tmo_mode = 1'b1;
        set_req(1, 300, 400);
        wait_rsps(1, TIMEOUT_CYC + 40);
        check("tmo_err", rsp_err, 1);
        check("tmo_angle", $signed(rsp_angle), 0);
        check("tmo_lat", rsp_seen - start_seen, TIMEOUT_CYC + 1);
        stuck = 1'b0;
        tmo_mode = 1'b0;
        repeat (3) step();
        set_req(2, 300, 400);
        wait_rsps(1, 100);
        check("post_tmo_err", rsp_err, 0);
        check("post_tmo_id", rsp_id, 2);
`endif

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
